// File: rtl/rstgen.sv
`default_nettype none
// ============================================================================
//  Module   : rstgen
//  Purpose  : Reset sequencer and timebase. Waits for PLL lock, holds the
//             core in reset for HOLD_CYCLES stable-lock cycles, releases a
//             reset that deasserts synchronously to clk, and produces a
//             one-cycle tick every TICK_DIV cycles while running. Loss of
//             lock while running returns to reset and sets a sticky flag.
//  Ports    : clk        - system clock (only clock)
//             rst        - asynchronous active-high reset
//             pll_lock   - PLL lock indication (asynchronous to clk)
//             sys_rst    - active-high core reset (async assert, sync release)
//             ready      - high only while running (~sys_rst)
//             tick       - one-cycle pulse every TICK_DIV cycles while running
//             lock_lost  - sticky: lock dropped while running; cleared by rst
//  Revision : 1.0 - initial release
// ============================================================================
module rstgen #(
    parameter int HOLD_CYCLES = 16,
    parameter int TICK_DIV    = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    output logic sys_rst,
    output logic ready,
    output logic tick,
    output logic lock_lost
);

    // Counter widths hold exactly the terminal counts.
    localparam int c_hcw = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_tcw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_hcw-1:0] c_hold_last = c_hcw'(HOLD_CYCLES - 1);
    localparam logic [c_tcw-1:0] c_tick_last = c_tcw'(TICK_DIV - 1);
    localparam logic [c_hcw-1:0] c_hcnt_one  = c_hcw'(1);
    localparam logic [c_tcw-1:0] c_tcnt_one  = c_tcw'(1);

    localparam logic [1:0] c_st_hold = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    logic             r_sync_meta;
    logic             r_lock_s;
    logic [1:0]       r_state;
    logic [c_hcw-1:0] r_hcnt;
    logic [c_tcw-1:0] r_tcnt;
    logic             r_sys_rst;
    logic             r_tick;
    logic             r_lock_lost;

    logic [1:0]       w_state_nxt;
    logic [c_hcw-1:0] w_hcnt_nxt;
    logic [c_tcw-1:0] w_tcnt_nxt;
    logic             w_tick_nxt;
    logic             w_lock_lost_nxt;

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_lock;
            r_lock_s    <= r_sync_meta;
        end
    end

    // Next-state logic. Loss of synchronized lock always wins.
    always_comb begin
        w_state_nxt     = r_state;
        w_hcnt_nxt      = r_hcnt;
        w_tcnt_nxt      = r_tcnt;
        w_tick_nxt      = 1'b0;
        w_lock_lost_nxt = r_lock_lost;
        case (r_state)
            c_st_hold: begin
                if (r_lock_s) begin
                    w_state_nxt = c_st_wait;
                    w_hcnt_nxt  = '0;
                end
            end
            c_st_wait: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_st_hold;
                end else if (r_hcnt == c_hold_last) begin
                    w_state_nxt = c_st_run;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_hcnt_nxt = r_hcnt + c_hcnt_one;
                end
            end
            c_st_run: begin
                if (!r_lock_s) begin
                    w_state_nxt     = c_st_hold;
                    w_lock_lost_nxt = 1'b1;
                    w_tcnt_nxt      = '0;
                end else if (r_tcnt == c_tick_last) begin
                    // Tick is the registered image of the wrap, so it is
                    // high for the cycle after tcnt returns to 0.
                    w_tcnt_nxt = '0;
                    w_tick_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + c_tcnt_one;
                end
            end
            default: begin
                w_state_nxt = c_st_hold;
            end
        endcase
    end

    // State, counters and registered outputs. sys_rst tracks the next
    // state so it changes on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_hold;
            r_hcnt      <= '0;
            r_tcnt      <= '0;
            r_sys_rst   <= 1'b1;
            r_tick      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_sys_rst   <= (w_state_nxt != c_st_run);
            r_tick      <= w_tick_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign sys_rst   = r_sys_rst;
    assign ready     = ~r_sys_rst;
    assign tick      = r_tick;
    assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: doc/rstgen.md
# rstgen

Reset sequencer and timebase for the stack machine CPU. It sits directly downstream of `clkgen` and consumes its `clk`. It waits for PLL lock, holds the core in reset for a programmable settling time, then releases a reset that deasserts synchronously to `clk`. While running it provides a periodic one-cycle tick, and it re-enters reset if lock is lost.

## Interface
- `HOLD_CYCLES`, default 16: number of `clk` cycles that lock must stay stable before reset is released (legal range ≥1).
- `TICK_DIV`, default 100: tick period in `clk` cycles (legal range ≥2). 100 gives 1 µs at 100 MHz.
- `clk` input, 1 bit: system clock from `clkgen`. This is the only clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `pll_lock` input, 1 bit: PLL lock indication. Asynchronous to `clk`.
- `sys_rst` output, 1 bit: active-high core reset. Asserts asynchronously with `rst` and deasserts synchronously to `clk`.
- `ready` output, 1 bit: high only in RUN. Equals `~sys_rst`.
- `tick` output, 1 bit: one-cycle pulse every `TICK_DIV` cycles while in RUN.
- `lock_lost` output, 1 bit: sticky flag, set when lock drops during RUN. Cleared only by `rst`.

## Operation
- **Lock synchronizer:** 2-flop synchronizer on `pll_lock`. Its output is `lock_s`. Both flops reset to 0.
- **State machine:** states HOLD, WAIT, RUN. Reset state is HOLD.
- **HOLD:**
  - If `lock_s`=1: go to WAIT and set `hcnt`=0.
  - Otherwise stay in HOLD.
- **WAIT:**
  - If `lock_s`=0: go to HOLD. Lock has priority.
  - Else if `hcnt`==`HOLD_CYCLES`-1: go to RUN and set `tcnt`=0.
  - Else increment `hcnt`.
- **RUN:**
  - If `lock_s`=0: go to HOLD, set `lock_lost`=1, clear `tcnt`.
  - Otherwise `tcnt` counts 0..`TICK_DIV`-1 and wraps to 0.
- **Outputs:**
  - `sys_rst` is registered and updates on the same edge as the state register: it is 1 when the next state is not RUN.
  - `tick` is registered: it is 1 for the single cycle following the edge at which `tcnt` wraps from `TICK_DIV`-1 to 0.
  - Outside RUN, `tick` is forced to 0.
- **Counter widths:** `hcnt` and `tcnt` are each sized to hold `HOLD_CYCLES`-1 and `TICK_DIV`-1 respectively. They are unsigned and never exceed their terminal count.
- **Reset values:**
  - `sys_rst`=1, `ready`=0, `tick`=0, `lock_lost`=0.
  - State is HOLD, `hcnt`=0, `tcnt`=0, synchronizer flops 0.

## Timing
- **`rst` assertion:** all outputs and state take their reset values immediately, with no clock required. This includes assertion mid-WAIT or mid-RUN.
- **Power-up latency:** with `pll_lock` high and `rst` released before edge 1:
  - `lock_s`=1 after edge 2.
  - WAIT after edge 3.
  - RUN, `sys_rst`=0, `ready`=1 after edge 3+`HOLD_CYCLES`. This is edge 19 at the default.
- **First tick:** the first `tick` pulse is high after edge 3+`HOLD_CYCLES`+`TICK_DIV`. After that, pulses repeat exactly every `TICK_DIV` cycles.
- **Lock drop in RUN:** `pll_lock` falls before edge n, so `lock_s`=0 after edge n+1. After edge n+2: `sys_rst`=1, `ready`=0, `lock_lost`=1, and `tick`=0. A tick scheduled for that edge is suppressed.
- **Lock glitch in WAIT:** a glitch that reaches `lock_s` returns the machine to HOLD. The full `HOLD_CYCLES` count restarts on the next lock.
- **Glitches shorter than one `clk` period:** these may or may not be captured. Either outcome is legal.
- **Re-lock after loss:** the full HOLD→WAIT→RUN sequence repeats. `lock_lost` stays 1.
- **`HOLD_CYCLES`=1:** WAIT lasts exactly one cycle.
- **`TICK_DIV`=2:** `tick` alternates 1/0 in RUN.

## Test plan
- **Power-up:** `rst`=1 for 5 cycles, `pll_lock`=1 constant, release `rst` → `sys_rst`=1 through edge 18, then 0 with `ready`=1 after edge 19 (defaults).
- **Tick cadence:** run defaults for 1000 cycles after RUN → exactly 10 `tick` pulses, each 1 cycle wide, 100 cycles apart, first pulse after edge 119.
- **Lock loss in RUN:** drop `pll_lock` at cycle 150 → `sys_rst`=1 and `lock_lost`=1 two edges later. Restore lock → RUN again after 3+16 edges, with `lock_lost` still 1.
- **Lock glitch in WAIT:** drop `pll_lock` for 3 cycles at WAIT count 10 → back to HOLD. RUN is reached only 16 full WAIT cycles after re-lock.
- **Async reset mid-RUN:** assert `rst` between clock edges → `sys_rst`=1, `tick`=0, `lock_lost`=0, `ready`=0 with no clock edge.
- **Parameter corners:** `HOLD_CYCLES`=1, `TICK_DIV`=2 → RUN after edge 4, then `tick` toggles 1/0 every cycle.
